// File: rtl/shift_ctrl_pkg.sv
// Shared types and widths for the shift-sharing controller.
// SHIFT_WIDE_EN widens the request shift amount to 5 bits and enables the two-pass EXEC2 state.
package shift_ctrl_pkg;
  localparam int DATA_W   = 16;
  localparam int SH_AMT_W = 4;
  localparam int REQ_ID_W = 1;
`ifdef SHIFT_WIDE_EN
  localparam int AMT_W    = 5;
`else
  localparam int AMT_W    = 4;
`endif

  typedef enum logic [1:0] {IDLE, EXEC, EXEC2, RESP} state_t;
endpackage

// File: rtl/shift_share_ctrl_if.sv
// Request/response channels between the two requesters and the shift-sharing controller.
interface shift_share_ctrl_if import shift_ctrl_pkg::*; ();
  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_a;
  logic [AMT_W-1:0]  req0_b;
  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_a;
  logic [AMT_W-1:0]  req1_b;
  logic              rsp0_valid;
  logic              rsp0_ready;
  logic              rsp1_valid;
  logic              rsp1_ready;
  logic [DATA_W-1:0] rsp_c;
  logic              rsp_cout;

  modport master (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_c, rsp_cout
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_c, rsp_cout
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: on a tie the requester that was not served last wins.
module rr_arb2 (
  input  logic [1:0] i_valid,
  input  logic       i_rr_ptr,
  output logic [1:0] o_grant
);
  always_comb begin
    o_grant = 2'b00;
    case (i_valid)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = i_rr_ptr ? 2'b01 : 2'b10;
      default: o_grant = 2'b00;
    endcase
  end
endmodule

// File: rtl/shift_share_ctrl.sv
// Shares one external 16-bit left shifter between two requesters (IDLE -> EXEC -> RESP).
// Define SHIFT_WIDE_EN for 5-bit amounts; amounts >= 16 take an extra EXEC2 pass.
module shift_share_ctrl import shift_ctrl_pkg::*; (
  input  logic                clk,
  input  logic                rst_n,
  shift_share_ctrl_if.slave   bus,
  output logic [DATA_W-1:0]   sh_a,
  output logic [SH_AMT_W-1:0] sh_b,
  input  logic [DATA_W-1:0]   sh_c,
  input  logic                sh_cout,
  output logic                busy
);
  state_t                r_state;
  logic                  r_rr_ptr;
  logic                  r_rr_vld;
  logic [REQ_ID_W-1:0]   r_id;
  logic [DATA_W-1:0]     r_sh_a;
  logic [SH_AMT_W-1:0]   r_sh_b;
  logic [DATA_W-1:0]     r_rsp_c;
  logic                  r_rsp_cout;
  logic [1:0]            r_rsp_valid;
  logic                  r_busy;
  logic [1:0]            w_grant;
  logic                  w_rr_last;
  logic [AMT_W-1:0]      w_amt;
  logic                  w_rsp_ready;
`ifdef SHIFT_WIDE_EN
  logic                  r_two;
  logic [AMT_W-1:0]      r_amt2;
`endif

  // Until the first handshake nobody has been served; treat req1 as last served.
  assign w_rr_last   = r_rr_vld ? r_rr_ptr : 1'b1;
  assign w_amt       = w_grant[1] ? bus.req1_b : bus.req0_b;
  assign w_rsp_ready = r_id[0] ? bus.rsp1_ready : bus.rsp0_ready;

  rr_arb2 u_arb (
    .i_valid  ({bus.req1_valid, bus.req0_valid} & {2{r_state == IDLE}}),
    .i_rr_ptr (w_rr_last),
    .o_grant  (w_grant)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_rr_ptr    <= 1'b0;
      r_rr_vld    <= 1'b0;
      r_id        <= '0;
      r_sh_a      <= '0;
      r_sh_b      <= '0;
      r_rsp_c     <= '0;
      r_rsp_cout  <= 1'b0;
      r_rsp_valid <= 2'b00;
      r_busy      <= 1'b0;
`ifdef SHIFT_WIDE_EN
      r_two       <= 1'b0;
      r_amt2      <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (|w_grant) begin
            r_id   <= w_grant[1];
            r_sh_a <= w_grant[1] ? bus.req1_a : bus.req0_a;
`ifdef SHIFT_WIDE_EN
            r_two  <= w_amt[4];
            r_amt2 <= w_amt - AMT_W'(15);
            r_sh_b <= w_amt[4] ? SH_AMT_W'(15) : w_amt[SH_AMT_W-1:0];
`else
            r_sh_b <= w_amt;
`endif
            r_busy  <= 1'b1;
            r_state <= EXEC;
          end
        end
        EXEC: begin
`ifdef SHIFT_WIDE_EN
          if (r_two) begin
            r_sh_a     <= sh_c;
            r_sh_b     <= r_amt2[SH_AMT_W-1:0];
            r_rsp_cout <= sh_cout;
            r_state    <= EXEC2;
          end else
`endif
          begin
            r_rsp_c     <= sh_c;
            r_rsp_cout  <= sh_cout;
            r_sh_a      <= '0;
            r_sh_b      <= '0;
            r_rsp_valid <= r_id[0] ? 2'b10 : 2'b01;
            r_state     <= RESP;
          end
        end
`ifdef SHIFT_WIDE_EN
        EXEC2: begin
          // A second-pass amount of 16 cannot be expressed on sh_b: everything left shifts out.
          r_rsp_c     <= r_amt2[4] ? '0 : sh_c;
          r_rsp_cout  <= r_rsp_cout | sh_cout | (r_amt2[4] & (|sh_c));
          r_sh_a      <= '0;
          r_sh_b      <= '0;
          r_rsp_valid <= r_id[0] ? 2'b10 : 2'b01;
          r_state     <= RESP;
        end
`endif
        RESP: begin
          if (w_rsp_ready) begin
            r_rsp_valid <= 2'b00;
            r_rr_ptr    <= r_id[0];
            r_rr_vld    <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req0_ready = w_grant[0];
  assign bus.req1_ready = w_grant[1];
  assign bus.rsp0_valid = r_rsp_valid[0];
  assign bus.rsp1_valid = r_rsp_valid[1];
  assign bus.rsp_c      = r_rsp_c;
  assign bus.rsp_cout   = r_rsp_cout;
  assign sh_a           = r_sh_a;
  assign sh_b           = r_sh_b;
  assign busy           = r_busy;
endmodule

// File: tb/tb_shift_share_ctrl.sv
// Directed bench for shift_share_ctrl with a behavioural 16-bit shifter on the sh_* port.
module tb_shift_share_ctrl;
  import shift_ctrl_pkg::*;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [DATA_W-1:0]   sh_a;
  logic [SH_AMT_W-1:0] sh_b;
  logic [DATA_W-1:0]   sh_c;
  logic                sh_cout;
  logic                busy;
  logic [31:0]         w_shift;
  int                  n_tests = 0;
  int                  n_fail  = 0;

  typedef struct {
    logic             id;
    logic [15:0]      a;
    logic [AMT_W-1:0] b;
    logic [15:0]      c;
    logic             cout;
  } vec_t;

  vec_t vecs[8];

  shift_share_ctrl_if vif ();

  shift_share_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (vif),
    .sh_a    (sh_a),
    .sh_b    (sh_b),
    .sh_c    (sh_c),
    .sh_cout (sh_cout),
    .busy    (busy)
  );

  assign w_shift = {16'h0000, sh_a} << sh_b;
  assign sh_c    = w_shift[15:0];
  assign sh_cout = |w_shift[31:16];

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_sh_a"}, 32'(sh_a), 32'd0);
    check({tag, "_sh_b"}, 32'(sh_b), 32'd0);
    check({tag, "_rsp_c"}, 32'(vif.rsp_c), 32'd0);
    check({tag, "_rsp_cout"}, 32'(vif.rsp_cout), 32'd0);
    check({tag, "_rsp_valid"}, 32'({vif.rsp1_valid, vif.rsp0_valid}), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    vif.req0_valid = 1'b0;
    vif.req1_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_op(input logic id, input logic [15:0] a, input logic [AMT_W-1:0] b,
                        input logic [15:0] ec, input logic ecout, input int exp_lat);
    int   edges;
    logic got;
    logic [SH_AMT_W-1:0] b_lo;
    b_lo = b[SH_AMT_W-1:0];
    @(negedge clk);
    if (id) begin
      vif.req1_valid = 1'b1; vif.req1_a = a; vif.req1_b = b;
    end else begin
      vif.req0_valid = 1'b1; vif.req0_a = a; vif.req0_b = b;
    end
    #1;
    check("req_ready", 32'({vif.req1_ready, vif.req0_ready}), id ? 32'd2 : 32'd1);
    @(negedge clk);
    vif.req0_valid = 1'b0;
    vif.req1_valid = 1'b0;
    check("busy_exec", 32'(busy), 32'd1);
    if (exp_lat == 2) begin
      check("exec_sh_a", 32'(sh_a), 32'(a));
      check("exec_sh_b", 32'(sh_b), 32'(b_lo));
    end
    edges = 1;
    got   = 1'b0;
    while (!got && edges < 10) begin
      @(negedge clk);
      edges++;
      got = id ? vif.rsp1_valid : vif.rsp0_valid;
    end
    check("latency", 32'(edges), 32'(exp_lat));
    check("rsp_c", 32'(vif.rsp_c), 32'(ec));
    check("rsp_cout", 32'(vif.rsp_cout), 32'(ecout));
    check("other_rsp_valid", 32'(id ? vif.rsp0_valid : vif.rsp1_valid), 32'd0);
    check("resp_sh_a", 32'(sh_a), 32'd0);
    @(negedge clk);
    check("busy_after", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [1:0] exp_g;
    vif.req0_valid = 1'b0; vif.req0_a = '0; vif.req0_b = '0;
    vif.req1_valid = 1'b0; vif.req1_a = '0; vif.req1_b = '0;
    vif.rsp0_ready = 1'b1; vif.rsp1_ready = 1'b1;

    vecs[0] = '{1'b0, 16'h00F1, AMT_W'(4),  16'h0F10, 1'b0};
    vecs[1] = '{1'b1, 16'h8001, AMT_W'(1),  16'h0002, 1'b1};
    vecs[2] = '{1'b0, 16'h1234, AMT_W'(0),  16'h1234, 1'b0};
    vecs[3] = '{1'b1, 16'hFFFF, AMT_W'(15), 16'h8000, 1'b1};
    vecs[4] = '{1'b0, 16'h0003, AMT_W'(15), 16'h8000, 1'b1};
    vecs[5] = '{1'b1, 16'h00FF, AMT_W'(8),  16'hFF00, 1'b0};
    vecs[6] = '{1'b0, 16'h0F00, AMT_W'(8),  16'h0000, 1'b1};
    vecs[7] = '{1'b1, 16'h0001, AMT_W'(15), 16'h8000, 1'b0};

    do_reset();
    #1;
    check_idle_outputs("reset");

    for (int i = 0; i < 8; i++)
      run_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].cout, 2);

    // Both requesters valid every cycle: alternating grants, one op every 3 cycles.
    do_reset();
    @(negedge clk);
    vif.req0_valid = 1'b1; vif.req0_a = 16'h0001; vif.req0_b = AMT_W'(1);
    vif.req1_valid = 1'b1; vif.req1_a = 16'h4000; vif.req1_b = AMT_W'(2);
    for (int c = 0; c < 12; c++) begin
      #1;
      exp_g = (c % 3 != 0) ? 2'b00 : (((c / 3) % 2 == 1) ? 2'b10 : 2'b01);
      check("rr_grant", 32'({vif.req1_ready, vif.req0_ready}), 32'(exp_g));
      if (c == 2) check("rr_rsp0_c", 32'({vif.rsp0_valid, vif.rsp_c}), 32'h0001_0002);
      if (c == 5) check("rr_rsp1_cout", 32'({vif.rsp1_valid, vif.rsp_cout, vif.rsp_c}), 32'h0003_0000);
      @(negedge clk);
    end
    vif.req0_valid = 1'b0;
    vif.req1_valid = 1'b0;

    // Response back-pressure: result held, no new grants while waiting.
    do_reset();
    vif.rsp0_ready = 1'b0;
    @(negedge clk);
    vif.req0_valid = 1'b1; vif.req0_a = 16'h00F1; vif.req0_b = AMT_W'(4);
    @(negedge clk);
    vif.req0_valid = 1'b0;
    vif.req1_valid = 1'b1; vif.req1_a = 16'h0001; vif.req1_b = AMT_W'(0);
    #1;
    check("bp_exec_ready", 32'({vif.req1_ready, vif.req0_ready}), 32'd0);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp_rsp0_valid", 32'(vif.rsp0_valid), 32'd1);
      check("bp_rsp_c", 32'({vif.rsp_cout, vif.rsp_c}), 32'h0000_0F10);
      check("bp_req_ready", 32'({vif.req1_ready, vif.req0_ready}), 32'd0);
      @(negedge clk);
    end
    vif.rsp0_ready = 1'b1;
    @(negedge clk);
    #1;
    check("bp_release_grant", 32'({vif.req1_ready, vif.req0_ready}), 32'd2);
    vif.req1_valid = 1'b0;
    @(negedge clk);

    // Reset during EXEC clears state and the round-robin history.
    do_reset();
    run_op(1'b0, 16'h00F1, AMT_W'(4), 16'h0F10, 1'b0, 2);
    @(negedge clk);
    vif.req0_valid = 1'b1; vif.req0_a = 16'h00F1; vif.req0_b = AMT_W'(4);
    @(negedge clk);
    vif.req0_valid = 1'b0;
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    check_idle_outputs("midrst");
    rst_n = 1'b1;
    @(negedge clk);
    vif.req0_valid = 1'b1;
    vif.req1_valid = 1'b1;
    #1;
    check("post_rst_tie", 32'({vif.req1_ready, vif.req0_ready}), 32'd1);
    vif.req0_valid = 1'b0;
    vif.req1_valid = 1'b0;
    @(negedge clk);

`ifdef SHIFT_WIDE_EN
    run_op(1'b0, 16'h0003, AMT_W'(17), 16'h0000, 1'b1, 3);
    run_op(1'b0, 16'h0003, AMT_W'(15), 16'h8000, 1'b1, 2);
    run_op(1'b1, 16'h0001, AMT_W'(31), 16'h0000, 1'b1, 3);
    run_op(1'b1, 16'h0001, AMT_W'(16), 16'h0000, 1'b1, 3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
